decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered instruction-decode stage for the RV32I core; sits between fetch and execute.
- Accepts one instruction per cycle over a valid/ready handshake and decodes the full RV32I base opcode set: R, I-ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR.
- Generates format-correct immediates and holds the decoded bundle in an output register.
- Inserts a one-cycle bubble on load-use hazards and supports pipeline flush.

Parameters:
- XLEN, 32, datapath width; PC and immediate width; immediate sign-extended to XLEN.
- ALU_OP_W, 4, width of the alu_op field; must be at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discards the output register and the current input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered PC.
- out_alu_op  out  ALU_OP_W  ALU operation.
- out_alu_src  out  2  operand select: 00 = rs2, 01 = imm, 10 = PC/imm (AUIPC), 11 = PC/4 (link).
- out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump  out  1 each  control flags.
- out_funct3  out  3  passed through for branch and load/store sizing.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_illegal  out  1  unknown opcode or funct.

Behaviour:
- Reset: out_valid = 0 and every out_* = 0. in_ready follows the combinational rule below with out_valid = 0.
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !flush & !hazard & (!out_valid | out_ready).
  - On in_fire the output register loads the decoded bundle and out_valid = 1.
  - Otherwise, on out_fire, out_valid = 0.
  - Latency is 1 cycle. Throughput is 1 instruction per cycle when no hazard or backpressure is present.
- Backpressure: while out_valid & !out_ready, every out_* field holds stable.
- alu_op encoding:
  - ADD = 0, SUB = 1, SLL = 2, SLT = 3, SLTU = 4, XOR = 5, SRL = 6, SRA = 7, OR = 8, AND = 9, PASSB = 10.
  - R-type uses funct7[5] to select SUB and SRA.
  - I-ALU uses funct7[5] only for SRAI.
  - LOAD, STORE, AUIPC, JAL and JALR use ADD.
  - LUI uses PASSB.
  - BRANCH uses SUB.
- Immediate formats:
  - I-format: LOAD, I-ALU, JALR.
  - S-format: STORE.
  - B-format: BRANCH, with bit0 = 0.
  - U-format: LUI and AUIPC, with low 12 bits = 0.
  - J-format: JAL, with bit0 = 0.
  - R-type: imm = 0.
  - Sign bit is always inst[31], extended to XLEN.
- Control flags:
  - reg_write = 1 for R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR.
  - reg_write is forced 0 when rd = 0.
  - branch = 1 for BRANCH only.
  - jump = 1 for JAL and JALR.
- Illegal instruction:
  - Triggers on an unknown opcode, or on R-type funct7 not in {0x00, 0x20}, or on 0x20 with funct3 not in {000, 101}.
  - Effect: out_illegal = 1 and all write/memory flags = 0. The bundle is still registered and handed over.
- Load-use hazard:
  - hazard = out_valid & out_mem_read & out_rd != 0 & in_valid & ((uses_rs1 & rs1 == out_rd) | (uses_rs2 & rs2 == out_rd)).
  - uses_rs1 for R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for R, STORE, BRANCH.
  - Effect: when the load fires, out_valid drops for exactly one cycle (bubble), then the consumer is accepted.
- Flush:
  - Takes priority over everything else.
  - On a flush edge: out_valid = 0 and the input is not accepted, since in_ready = 0.
  - An out_fire coinciding with flush still counts as consumed downstream.
- Reset mid-transfer: the pending bundle is lost and out_valid = 0 immediately.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_issued [31:0], perf_bubbles [31:0] and perf_illegal [31:0].
  - perf_issued increments on out_fire.
  - perf_bubbles increments each cycle hazard = 1.
  - perf_illegal increments on out_fire with out_illegal.
  - All three reset to 0 and wrap at 2^32.
- Undefined: the ports and the counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then stream ADD x3,x1,x2 (0x002081B3) and ADDI x5,x0,-1 (0xFFF00293) with out_ready = 1 → accepted back-to-back.
  - ADD bundle one cycle after acceptance: alu_op = 0, alu_src = 00, reg_write = 1, rd = 3.
  - ADDI bundle next cycle: imm = 0xFFFFFFFF, alu_src = 01.
- SW x2,8(x1) (0x0020A423), BEQ x1,x2,-4 (0xFE208EE3) and JAL x1,+2048 (0x001000EF) → decoded immediates are:
  - SW: imm = 8, mem_write = 1, reg_write = 0.
  - BEQ: imm = 0xFFFFFFFC, branch = 1, alu_op = 1.
  - JAL: imm = 0x800, jump = 1, alu_src = 11.
- LW x5,0(x1) followed immediately by ADD x6,x5,x5 → one bubble: out_valid = 0 for one cycle between them; with DECODE_PERF_CNT_EN, perf_bubbles = 1.
- Hold out_ready = 0 for 3 cycles with SUB pending → in_ready = 0, outputs stable; on release the next instruction issues with no loss or duplication.
- Assert flush with a valid bundle pending and in_valid = 1 → out_valid = 0 the next cycle and the input is not accepted; the fetch re-presents it after flush.
- Opcode 0x7F, and R-type with funct7 = 0x01 → out_illegal = 1 with reg_write, mem_read and mem_write all 0.

Source files
------------

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side bus of the RV32I decode stage.
//
// Parameters:
//   XLEN     - datapath width (PC and immediate)
//   ALU_OP_W - width of the alu_op field
//
// Modports:
//   master - the decode stage. It drives in_ready and the registered out_* bundle.
//            It receives flush, in_valid, in_inst, in_pc and out_ready.
//   slave  - the surrounding pipeline (fetch, execute and flush control).
//            It is the mirror image of master.
interface decode_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [1:0]          out_alu_src;
    logic                out_mem_read;
    logic                out_mem_write;
    logic                out_reg_write;
    logic                out_branch;
    logic                out_jump;
    logic [2:0]          out_funct3;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [XLEN-1:0]     out_imm;
    logic                out_illegal;

    modport master (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op, out_alu_src,
               out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump,
               out_funct3, out_rs1, out_rs2, out_rd, out_imm, out_illegal
    );

    modport slave (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op, out_alu_src,
               out_mem_read, out_mem_write, out_reg_write, out_branch, out_jump,
               out_funct3, out_rs1, out_rs2, out_rd, out_imm, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode stage between fetch and execute.
//
// The stage decodes one instruction per cycle. It accepts the instruction over a
// valid/ready handshake and holds the decoded bundle in an output register. It
// stalls for one cycle on a load-use hazard. Flush has priority over all other
// inputs.
//
// Ports:
//   clk  - clock; all state is updated on the rising edge.
//   rst  - asynchronous active-high reset.
//   bus  - decode_stage_if.master. It carries:
//            fetch side:   in_valid, in_ready, in_inst, in_pc
//            flush
//            execute side: out_valid, out_ready and the out_* decoded fields.
//
// Optional feature (macro DECODE_PERF_CNT_EN):
//   When the macro is defined, three 32-bit wrapping counters are added as outputs:
//     perf_issued  - number of bundles consumed by execute.
//     perf_bubbles - number of cycles stalled by a load-use hazard.
//     perf_illegal - number of illegal bundles consumed by execute.
module decode_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DECODE_PERF_CNT_EN
    output logic [31:0] perf_issued,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_illegal,
`endif
    decode_stage_if.master bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASSB = ALU_OP_W'(10);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

    // Builds the 32-bit immediate for the given format. Every format takes its
    // sign bit from inst[31]. The B and J formats have an implicit zero in bit 0.
    function automatic logic signed [31:0] imm_gen(input logic [31:0] inst,
                                                   input imm_fmt_t    fmt);
        logic signed [31:0] imm;
        case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'h000};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // Maps funct3 to an ALU operation. 'alt' is funct7[5] and selects SUB or SRA.
    function automatic logic [ALU_OP_W-1:0] alu_funct(input logic [2:0] f3,
                                                      input logic       alt);
        logic [ALU_OP_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = bus.in_inst[6:0];
    assign rd     = bus.in_inst[11:7];
    assign funct3 = bus.in_inst[14:12];
    assign rs1    = bus.in_inst[19:15];
    assign rs2    = bus.in_inst[24:20];
    assign funct7 = bus.in_inst[31:25];

    // ---- stage p0: combinational decode of the presented instruction ----
    logic [ALU_OP_W-1:0]    alu_op_p0;
    logic [1:0]             alu_src_p0;
    logic                   mem_read_p0, mem_write_p0, reg_write_p0;
    logic                   branch_p0, jump_p0, illegal_p0;
    logic                   uses_rs1_p0, uses_rs2_p0;
    imm_fmt_t               fmt_p0;
    logic signed [XLEN-1:0] imm_p0;

    always_comb begin
        alu_op_p0    = ALU_ADD;
        alu_src_p0   = 2'b00;
        mem_read_p0  = 1'b0;
        mem_write_p0 = 1'b0;
        reg_write_p0 = 1'b0;
        branch_p0    = 1'b0;
        jump_p0      = 1'b0;
        illegal_p0   = 1'b0;
        uses_rs1_p0  = 1'b0;
        uses_rs2_p0  = 1'b0;
        fmt_p0       = FMT_R;
        case (opcode)
            OP_R: begin
                reg_write_p0 = 1'b1;
                uses_rs1_p0  = 1'b1;
                uses_rs2_p0  = 1'b1;
                if (funct7 == 7'h00)
                    alu_op_p0 = alu_funct(funct3, 1'b0);
                else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))
                    alu_op_p0 = alu_funct(funct3, 1'b1);
                else
                    illegal_p0 = 1'b1;
            end
            OP_IALU: begin
                // funct7[5] matters only for SRAI. An ADDI with bit 30 set stays ADD.
                alu_op_p0    = alu_funct(funct3, (funct3 == 3'b101) & funct7[5]);
                alu_src_p0   = 2'b01;
                reg_write_p0 = 1'b1;
                uses_rs1_p0  = 1'b1;
                fmt_p0       = FMT_I;
            end
            OP_LOAD: begin
                alu_src_p0   = 2'b01;
                mem_read_p0  = 1'b1;
                reg_write_p0 = 1'b1;
                uses_rs1_p0  = 1'b1;
                fmt_p0       = FMT_I;
            end
            OP_STORE: begin
                alu_src_p0   = 2'b01;
                mem_write_p0 = 1'b1;
                uses_rs1_p0  = 1'b1;
                uses_rs2_p0  = 1'b1;
                fmt_p0       = FMT_S;
            end
            OP_BRANCH: begin
                alu_op_p0   = ALU_SUB;
                branch_p0   = 1'b1;
                uses_rs1_p0 = 1'b1;
                uses_rs2_p0 = 1'b1;
                fmt_p0      = FMT_B;
            end
            OP_LUI: begin
                alu_op_p0    = ALU_PASSB;
                alu_src_p0   = 2'b01;
                reg_write_p0 = 1'b1;
                fmt_p0       = FMT_U;
            end
            OP_AUIPC: begin
                alu_src_p0   = 2'b10;
                reg_write_p0 = 1'b1;
                fmt_p0       = FMT_U;
            end
            OP_JAL: begin
                alu_src_p0   = 2'b11;
                reg_write_p0 = 1'b1;
                jump_p0      = 1'b1;
                fmt_p0       = FMT_J;
            end
            OP_JALR: begin
                alu_src_p0   = 2'b11;
                reg_write_p0 = 1'b1;
                jump_p0      = 1'b1;
                uses_rs1_p0  = 1'b1;
                fmt_p0       = FMT_I;
            end
            default: illegal_p0 = 1'b1;
        endcase
        // An illegal bundle still flows to execute, but it must not change any
        // architectural state.
        if (illegal_p0) begin
            reg_write_p0 = 1'b0;
            mem_read_p0  = 1'b0;
            mem_write_p0 = 1'b0;
        end
        if (rd == 5'd0)
            reg_write_p0 = 1'b0;
        imm_p0 = XLEN'(imm_gen(bus.in_inst, fmt_p0));
    end

    // ---- stage p1: output register ----
    logic                   vld_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [ALU_OP_W-1:0]    alu_op_p1;
    logic [1:0]             alu_src_p1;
    logic                   mem_read_p1, mem_write_p1, reg_write_p1;
    logic                   branch_p1, jump_p1, illegal_p1;
    logic [2:0]             funct3_p1;
    logic [4:0]             rs1_p1, rs2_p1, rd_p1;
    logic signed [XLEN-1:0] imm_p1;

    logic hazard, in_ready, in_fire, out_fire;

    // Stall while a load still sits in the output register and the presented
    // instruction reads the load's destination.
    assign hazard   = vld_p1 & mem_read_p1 & (rd_p1 != 5'd0) & bus.in_valid &
                      ((uses_rs1_p0 & (rs1 == rd_p1)) | (uses_rs2_p0 & (rs2 == rd_p1)));
    assign in_ready = !bus.flush & !hazard & (!vld_p1 | bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = vld_p1 & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            pc_p1        <= '0;
            alu_op_p1    <= '0;
            alu_src_p1   <= '0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            reg_write_p1 <= 1'b0;
            branch_p1    <= 1'b0;
            jump_p1      <= 1'b0;
            illegal_p1   <= 1'b0;
            funct3_p1    <= '0;
            rs1_p1       <= '0;
            rs2_p1       <= '0;
            rd_p1        <= '0;
            imm_p1       <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1       <= 1'b1;
            pc_p1        <= bus.in_pc;
            alu_op_p1    <= alu_op_p0;
            alu_src_p1   <= alu_src_p0;
            mem_read_p1  <= mem_read_p0;
            mem_write_p1 <= mem_write_p0;
            reg_write_p1 <= reg_write_p0;
            branch_p1    <= branch_p0;
            jump_p1      <= jump_p0;
            illegal_p1   <= illegal_p0;
            funct3_p1    <= funct3;
            rs1_p1       <= rs1;
            rs2_p1       <= rs2;
            rd_p1        <= rd;
            imm_p1       <= imm_p0;
        end else if (out_fire) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = vld_p1;
    assign bus.out_pc        = pc_p1;
    assign bus.out_alu_op    = alu_op_p1;
    assign bus.out_alu_src   = alu_src_p1;
    assign bus.out_mem_read  = mem_read_p1;
    assign bus.out_mem_write = mem_write_p1;
    assign bus.out_reg_write = reg_write_p1;
    assign bus.out_branch    = branch_p1;
    assign bus.out_jump      = jump_p1;
    assign bus.out_funct3    = funct3_p1;
    assign bus.out_rs1       = rs1_p1;
    assign bus.out_rs2       = rs2_p1;
    assign bus.out_rd        = rd_p1;
    assign bus.out_imm       = imm_p1;
    assign bus.out_illegal   = illegal_p1;

`ifdef DECODE_PERF_CNT_EN
    // A handover that coincides with a flush still counts as issued, because
    // execute has taken the bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued  <= '0;
            perf_bubbles <= '0;
            perf_illegal <= '0;
        end else begin
            if (out_fire)
                perf_issued <= perf_issued + 32'd1;
            if (hazard)
                perf_bubbles <= perf_bubbles + 32'd1;
            if (out_fire & illegal_p1)
                perf_illegal <= perf_illegal + 32'd1;
        end
    end
`endif

endmodule
